// File: rtl/servo_pkg.sv
// Shared types, widths and parameter-derived helpers for the servo pulse decoder.
package servo_pkg;

    localparam int unsigned US_W  = 16;  // microsecond counters and width_us
    localparam int unsigned POS_W = 8;   // position / quotient width
    localparam int unsigned NUM_W = 20;  // scaler dividend: (w - MIN) * 255
    localparam int unsigned DEN_W = 12;  // scaler divisor: MAX - MIN

    localparam logic [US_W-1:0] US_SAT = '1;

    typedef enum logic [2:0] {
        S_WAIT_LOW,
        S_IDLE,
        S_HIGH,
        S_CHECK,
        S_LOW
    } state_t;

    // Clock cycles per microsecond.
    function automatic int unsigned calc_div(input int unsigned clk_freq_hz);
        return clk_freq_hz / 1000000;
    endfunction

    // Narrowest width still accepted (and clamped up to MIN).
    function automatic int unsigned width_lo(input int unsigned min_us, input int unsigned tol_us);
        return min_us - tol_us;
    endfunction

    // Widest width still accepted (and clamped down to MAX).
    function automatic int unsigned width_hi(input int unsigned max_us, input int unsigned tol_us);
        return max_us + tol_us;
    endfunction

endpackage

// File: rtl/servo_scale_div.sv
// Sequential restoring divider: 20-bit dividend / 12-bit divisor -> 8-bit quotient.
// The quotient is known to fit in 8 bits, so the partial remainder is seeded
// with the dividend's upper 12 bits and only 8 restoring steps are needed.
// done is a one-cycle strobe exactly 9 cycles after the start cycle.
module servo_scale_div
    import servo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             last,
    output logic             done,
    output logic [POS_W-1:0] quot
);

    localparam logic [2:0] LAST_ITER = 3'(POS_W - 1);

    logic [DEN_W-1:0] rem_q,  rem_d;
    logic [POS_W-1:0] bits_q, bits_d;
    logic [2:0]       iter_q, iter_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [POS_W-1:0] quot_q, quot_d;
    logic [DEN_W:0]   trial;
    logic             fits;

    // Load on start, then one shift-and-subtract step per cycle
    always_comb begin
        trial  = {rem_q, bits_q[POS_W-1]};
        fits   = (trial >= {1'b0, divisor});
        rem_d  = rem_q;
        bits_d = bits_q;
        iter_d = iter_q;
        busy_d = busy_q;
        done_d = 1'b0;
        quot_d = quot_q;
        last   = busy_q && (iter_q == LAST_ITER);
        if (busy_q) begin
            rem_d  = fits ? DEN_W'(trial - {1'b0, divisor}) : DEN_W'(trial);
            bits_d = {bits_q[POS_W-2:0], fits};
            iter_d = iter_q + 3'(1);
            if (last) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                quot_d = {bits_q[POS_W-2:0], fits};
            end
        end else if (start) begin
            rem_d  = dividend[NUM_W-1:POS_W];
            bits_d = dividend[POS_W-1:0];
            iter_d = '0;
            busy_d = 1'b1;
        end
    end

    // Divider state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            bits_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            quot_q <= '0;
        end else begin
            rem_q  <= rem_d;
            bits_q <= bits_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
            quot_q <= quot_d;
        end
    end

    assign done = done_q;
    assign quot = quot_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// RC-servo pulse decoder: measures pulse high time in microseconds, maps
// accepted widths onto an 8-bit position, flags bad widths and signal loss.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50000000,
    parameter int unsigned PULSE_MIN_US = 1000,
    parameter int unsigned PULSE_MAX_US = 2000,
    parameter int unsigned TOL_US       = 250,
    parameter int unsigned TIMEOUT_US   = 25000
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [POS_W-1:0] pos,
    output logic             pos_valid,
    output logic [US_W-1:0]  width_us,
    output logic             err_width,
    output logic             signal_ok
);

    localparam int unsigned      DIV      = calc_div(CLK_FREQ_HZ);
    localparam int unsigned      PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [US_W-1:0]  MIN_W    = US_W'(PULSE_MIN_US);
    localparam logic [US_W-1:0]  MAX_W    = US_W'(PULSE_MAX_US);
    localparam logic [US_W-1:0]  LO_LIM   = US_W'(width_lo(PULSE_MIN_US, TOL_US));
    localparam logic [US_W-1:0]  HI_LIM   = US_W'(width_hi(PULSE_MAX_US, TOL_US));
    localparam logic [US_W-1:0]  TMO_LAST = US_W'(TIMEOUT_US - 1);
    localparam logic [DEN_W-1:0] RANGE_W  = DEN_W'(PULSE_MAX_US - PULSE_MIN_US);

    if (CLK_FREQ_HZ < 1000000 || (CLK_FREQ_HZ % 1000000) != 0) begin : g_bad_clk
        $error("CLK_FREQ_HZ must be a non-zero multiple of 1000000");
    end
    if (PULSE_MAX_US <= PULSE_MIN_US || (PULSE_MAX_US - PULSE_MIN_US) > 4095) begin : g_bad_range
        $error("PULSE_MAX_US - PULSE_MIN_US must be 1..4095");
    end
    if (TOL_US >= PULSE_MIN_US) begin : g_bad_tol
        $error("TOL_US must be below PULSE_MIN_US");
    end

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;   // [0],[1] synchronizer, [2] previous synced value
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [US_W-1:0]  width_cnt_q, width_cnt_d;
    logic [US_W-1:0]  per_cnt_q, per_cnt_d;
    logic [US_W-1:0]  width_us_q, width_us_d;
    logic             err_q, err_d;
    logic             signal_ok_q, signal_ok_d;

    logic             rise, fall, tick, timeout;
    logic [US_W-1:0]  w_clamp;
    logic [DEN_W-1:0] w_off;
    logic             div_start;
    logic [NUM_W-1:0] div_num;
    logic             div_last, div_done;
    logic [POS_W-1:0] div_quot;

    // Input synchronizer, edge detect, microsecond prescaler and us counters
    always_comb begin
        sync_d      = {sync_q[1:0], pwm_in};
        rise        = sync_q[1] & ~sync_q[2];
        fall        = ~sync_q[1] & sync_q[2];
        tick        = (pre_q == PRE_LAST);
        pre_d       = tick ? '0 : pre_q + PRE_W'(1);
        width_cnt_d = width_cnt_q;
        per_cnt_d   = per_cnt_q;
        if (tick && width_cnt_q != US_SAT) width_cnt_d = width_cnt_q + US_W'(1);
        if (tick && per_cnt_q != US_SAT)   per_cnt_d   = per_cnt_q + US_W'(1);
        // Single-cycle event: the tick that carries the period counter onto TIMEOUT_US
        timeout     = tick && (per_cnt_q == TMO_LAST) && !rise;
        if (rise) begin
            pre_d       = '0;
            width_cnt_d = '0;
            per_cnt_d   = '0;
        end
    end

    // Measurement FSM: next state, width check/clamp, scaler launch, status flags
    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        width_us_d  = width_us_q;
        signal_ok_d = signal_ok_q;
        div_start   = 1'b0;

        w_clamp = width_cnt_q;
        if (width_cnt_q < MIN_W)      w_clamp = MIN_W;
        else if (width_cnt_q > MAX_W) w_clamp = MAX_W;
        w_off   = DEN_W'(w_clamp - MIN_W);
        div_num = {w_off, {POS_W{1'b0}}} - {{POS_W{1'b0}}, w_off};  // w_off * 255

        case (state_q)
            S_WAIT_LOW: if (!sync_q[1]) state_d = S_IDLE;
            S_IDLE,
            S_LOW:      if (rise) state_d = S_HIGH;
            S_HIGH: begin
                if (fall) begin
                    state_d = S_CHECK;
                end else if (width_cnt_q > HI_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT_LOW;
                end
            end
            S_CHECK: begin
                width_us_d = width_cnt_q;
                if (width_cnt_q >= LO_LIM && width_cnt_q <= HI_LIM) div_start = 1'b1;
                else                                                err_d     = 1'b1;
                state_d = S_LOW;
            end
            default: state_d = S_WAIT_LOW;
        endcase

        if (timeout) begin
            signal_ok_d = 1'b0;
            if (state_q inside {S_WAIT_LOW, S_IDLE, S_LOW}) state_d = S_IDLE;
        end
        // Registered on the divider's final step so it rises with pos_valid
        if (div_last) signal_ok_d = 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT_LOW;
            sync_q      <= '1;
            pre_q       <= '0;
            width_cnt_q <= '0;
            per_cnt_q   <= '0;
            width_us_q  <= '0;
            err_q       <= 1'b0;
            signal_ok_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            pre_q       <= pre_d;
            width_cnt_q <= width_cnt_d;
            per_cnt_q   <= per_cnt_d;
            width_us_q  <= width_us_d;
            err_q       <= err_d;
            signal_ok_q <= signal_ok_d;
        end
    end

    servo_scale_div u_scale (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (RANGE_W),
        .last     (div_last),
        .done     (div_done),
        .quot     (div_quot)
    );

    assign pos       = div_quot;
    assign pos_valid = div_done;
    assign width_us  = width_us_q;
    assign err_width = err_q;
    assign signal_ok = signal_ok_q;

endmodule
